// File: rtl/lut_layer_sched.sv
// Sequences one layer input vector through NEURONS LUT evaluations on a shared ROM bank.
// Optional LUT_SCHED_PERF_EN adds perf_cnt, a saturating count of completed output handshakes.
module lut_layer_sched #(
  parameter int unsigned NEURONS  = 8,
  parameter int unsigned IN_W     = 32,
  parameter int unsigned OUT_BITS = 2,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              in_vec,
  output logic                         lut_en,
  output logic [SEL_W-1:0]             lut_sel,
  output logic [IN_W-1:0]              lut_vec,
  input  logic [OUT_BITS-1:0]          lut_data,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef LUT_SCHED_PERF_EN
  output logic [15:0]                  perf_cnt,
`endif
  output logic [NEURONS*OUT_BITS-1:0]  out_vec
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             en_q;
  logic [SEL_W-1:0] sel_q;
  logic             last_idx;

  assign last_idx = (idx_q == SEL_W'(NEURONS - 1));
  assign lut_sel  = idx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    lut_en    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = StIssue;
          idx_d   = '0;
        end
      end
      StIssue: begin
        lut_en = 1'b1;
        // idx stays at NEURONS-1 on exit so it never wraps past the last neuron
        if (last_idx) begin
          state_d = StDrain;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end
      StDrain: state_d = StDone;
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      en_q    <= 1'b0;
      sel_q   <= '0;
      lut_vec <= '0;
      out_vec <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // ROM answers one cycle after the request, so pair its data with the delayed select
      en_q    <= lut_en;
      sel_q   <= lut_sel;
      if (state_q == StIdle && in_valid) begin
        lut_vec <= in_vec;
      end
      if (en_q) begin
        for (int unsigned n = 0; n < NEURONS; n++) begin
          if (sel_q == SEL_W'(n)) begin
            out_vec[n*OUT_BITS +: OUT_BITS] <= lut_data;
          end
        end
      end
    end
  end

`ifdef LUT_SCHED_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (out_valid && out_ready && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_lut_layer_sched.sv
// Directed bench for lut_layer_sched: a 4-neuron instance with a registered ROM model
// and a 1-neuron instance with a constant ROM.
module tb_lut_layer_sched;

  logic clk;
  logic rst;

  logic        in_valid4, in_ready4, lut_en4, out_valid4, out_ready4;
  logic [31:0] in_vec4, lut_vec4;
  logic [1:0]  lut_sel4, lut_data4;
  logic [7:0]  out_vec4;

  logic        in_valid1, in_ready1, lut_en1, out_valid1, out_ready1;
  logic [31:0] in_vec1, lut_vec1;
  logic [0:0]  lut_sel1;
  logic [1:0]  lut_data1, out_vec1;

`ifdef LUT_SCHED_PERF_EN
  logic [15:0] perf4, perf1;
`endif

  bit rom_mode;
  int checks = 0;
  int errors = 0;
  int exp_perf = 0;

  lut_layer_sched #(.NEURONS(4), .IN_W(32), .OUT_BITS(2), .SEL_W(2)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_vec    (in_vec4),
    .lut_en    (lut_en4),
    .lut_sel   (lut_sel4),
    .lut_vec   (lut_vec4),
    .lut_data  (lut_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
`ifdef LUT_SCHED_PERF_EN
    .perf_cnt  (perf4),
`endif
    .out_vec   (out_vec4)
  );

  lut_layer_sched #(.NEURONS(1), .IN_W(32), .OUT_BITS(2), .SEL_W(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_vec    (in_vec1),
    .lut_en    (lut_en1),
    .lut_sel   (lut_sel1),
    .lut_vec   (lut_vec1),
    .lut_data  (lut_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
`ifdef LUT_SCHED_PERF_EN
    .perf_cnt  (perf1),
`endif
    .out_vec   (out_vec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: data = select; mode 1: data = select XOR the neuron's 2-bit slice of lut_vec
  always @(posedge clk) begin
    lut_data4 <= rom_mode ? (lut_sel4 ^ lut_vec4[int'(lut_sel4)*2 +: 2]) : lut_sel4;
  end
  assign lut_data1 = 2'b10;

  typedef struct {
    logic [31:0] vec;
    bit          mode;
    int          hold;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Starts and ends just after a falling edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    chk("idle_in_ready", in_ready4, 1);
    rom_mode  = v.mode;
    in_vec4   = v.vec;
    in_valid4 = 1'b1;
    out_ready4 = 1'b0;
    @(negedge clk);
    in_vec4 = ~v.vec;
    for (int c = 1; c <= 5; c++) begin
      chk("lut_en", lut_en4, c <= 4);
      if (c <= 4) chk("lut_sel", lut_sel4, c - 1);
      chk("busy_in_ready", in_ready4, 0);
      chk("early_out_valid", out_valid4, 0);
      @(negedge clk);
    end
    chk("out_valid", out_valid4, 1);
    chk("out_vec", out_vec4, v.exp);
    chk("lut_vec", lut_vec4, v.vec);
    for (int w = 0; w < v.hold; w++) begin
      @(negedge clk);
      chk("stall", {out_valid4, in_ready4, out_vec4}, {1'b1, 1'b0, v.exp});
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    @(negedge clk);
    exp_perf++;
    chk("rearm", {in_ready4, out_valid4}, 2'b10);
    out_ready4 = 1'b0;
  endtask

  initial begin
    int acc[3];
    int n;
    int waited;

    tbl[0] = '{32'hA5A5A5A5, 1'b0, 0, 8'hE4};
    tbl[1] = '{32'h000000FF, 1'b1, 5, 8'h1B};
    tbl[2] = '{32'h12345678, 1'b1, 0, 8'h9C};
    tbl[3] = '{32'hFFFFFF00, 1'b1, 2, 8'hE4};
    tbl[4] = '{32'hA5A5A5A5, 1'b1, 1, 8'h41};

    rst = 1'b1;
    rom_mode = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; in_vec4 = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_vec1 = 32'h5A5A0001;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready4, 1);
    chk("rst_lut_en", lut_en4, 0);
    chk("rst_lut_sel", lut_sel4, 0);
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_out_vec", out_vec4, 0);
    chk("rst_lut_vec", lut_vec4, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // continuous in_valid: accepts must be exactly 7 cycles apart
    rom_mode = 1'b0;
    in_vec4 = 32'h0F0F0F0F;
    in_valid4 = 1'b1;
    out_ready4 = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
      if (in_ready4) begin
        acc[n] = cyc;
        n++;
      end
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    chk("b2b_count", n, 3);
    chk("b2b_gap0", acc[1] - acc[0], 7);
    chk("b2b_gap1", acc[2] - acc[1], 7);
    waited = 0;
    while (!out_valid4 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("b2b_timeout", waited < 20, 1);
    chk("b2b_out_vec", out_vec4, 8'hE4);
    @(negedge clk);
    chk("b2b_rearm", in_ready4, 1);
    out_ready4 = 1'b0;

    // reset in the middle of a run
    in_vec4 = 32'hDEADBEEF;
    in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_perf = 0;
    chk("mid_rst_in_ready", in_ready4, 1);
    chk("mid_rst_lut_en", lut_en4, 0);
    chk("mid_rst_lut_sel", lut_sel4, 0);
    chk("mid_rst_out_valid", out_valid4, 0);
    chk("mid_rst_out_vec", out_vec4, 0);
    chk("mid_rst_lut_vec", lut_vec4, 0);
    @(negedge clk);
    chk("late_return_dropped", out_vec4, 0);
    run_vec(tbl[0]);
    run_vec(tbl[2]);
    run_vec(tbl[4]);

`ifdef LUT_SCHED_PERF_EN
    chk("perf_cnt", perf4, exp_perf);
`endif

    // single-neuron instance
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("n1_lut_en_on", lut_en1, 1);
    chk("n1_lut_sel", lut_sel1, 0);
    @(negedge clk);
    chk("n1_lut_en_off", lut_en1, 0);
    chk("n1_early_valid", out_valid1, 0);
    @(negedge clk);
    chk("n1_out_valid", out_valid1, 1);
    chk("n1_out_vec", out_vec1, 2'b10);
    out_ready1 = 1'b1;
    @(negedge clk);
    chk("n1_rearm", {in_ready1, out_valid1}, 2'b10);
    out_ready1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
